uart_rx_os16: RTL and testbench

UART_RX_OS16 -- requirements
Module: uart_rx_os16

---
 rtl/uart_rx_os16.sv | 214 +++++++++++++++++++++
 tb/tb_uart_rx_os16.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os16.sv
// Purpose : 16x-oversampled UART receiver (start + NUM_BITS data LSB first [+ even parity] + stop).
// Latency : Rx_valid pulses the clk after the mid-stop-bit sample, ~9.5 bit periods after the start edge.
// Backpressure: none. Rx_data is overwritten by each good frame, so the consumer must take it in the Rx_valid cycle.
// Build option: define UART_RX_PARITY_EN to add an even-parity bit and the PARITY state.
//               Without it, Rx_parity_err is tied low.

module uart_rx_os16 #(
    parameter int NUM_BITS = 8,   // data bits per frame, 5..8
    parameter int OS_RATE  = 16   // Rx_tick pulses per bit period, even and >= 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Rx_tick,
    input  logic                Rx_in,
    output logic [NUM_BITS-1:0] Rx_data,
    output logic                Rx_valid,
    output logic                Rx_busy,
    output logic                Rx_frame_err,
    output logic                Rx_parity_err
);

    localparam int TCW = $clog2(OS_RATE);
    localparam int BCW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    // START samples on the OS_RATE/2-th tick after entry.
    // Every later state samples on the OS_RATE-th tick.
    localparam logic [TCW-1:0] TICK_MID  = TCW'(OS_RATE / 2 - 1);
    localparam logic [TCW-1:0] TICK_LAST = TCW'(OS_RATE - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(NUM_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;
`endif

    state_t              state_q;
    logic                sync1_q;
    logic                rxs_q;
    logic [TCW-1:0]      tick_cnt_q;
    logic [BCW-1:0]      bit_cnt_q;
    logic [NUM_BITS-1:0] shift_q;
    logic [NUM_BITS-1:0] data_q;
    logic                valid_q;
    logic                ferr_q;
`ifdef UART_RX_PARITY_EN
    logic                par_bad_q;
    logic                perr_q;
`endif

    // Next values for the counters and the shift register.
    // A new bit enters at the MSB end, so the first bit received ends up in the LSB.
    logic [TCW-1:0]      tick_cnt_d;
    logic [BCW-1:0]      bit_cnt_d;
    logic [NUM_BITS-1:0] shift_d;

    assign tick_cnt_d = tick_cnt_q + TCW'(1);
    assign bit_cnt_d  = bit_cnt_q + BCW'(1);
    assign shift_d    = {rxs_q, shift_q[NUM_BITS-1:1]};

    // Two-flop synchronizer on the asynchronous serial line; it resets to the idle (high) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= Rx_in;
            rxs_q   <= sync1_q;
        end
    end

    // Frame FSM. Counters and state advance only on Rx_tick; the status pulses last one clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            // Status pulses default low so that each one lasts exactly one clk, even between ticks.
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            if (Rx_tick) begin
                case (state_q)
                    S_IDLE: begin
                        // A low line on any tick is a candidate start edge.
                        if (!rxs_q) begin
                            state_q    <= S_START;
                            tick_cnt_q <= '0;
                        end
                    end

                    S_START: begin
                        // Re-check the line at mid start bit.
                        // A high line here is a glitch, so the FSM goes back to IDLE without any pulse.
                        if (tick_cnt_q == TICK_MID) begin
                            tick_cnt_q <= '0;
                            bit_cnt_q  <= '0;
                            state_q    <= rxs_q ? S_IDLE : S_DATA;
                        end else begin
                            tick_cnt_q <= tick_cnt_d;
                        end
                    end

                    S_DATA: begin
                        if (tick_cnt_q == TICK_LAST) begin
                            tick_cnt_q <= '0;
                            shift_q    <= shift_d;
                            if (bit_cnt_q == BIT_LAST) begin
                                bit_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                                state_q   <= S_PARITY;
`else
                                state_q   <= S_STOP;
`endif
                            end else begin
                                bit_cnt_q <= bit_cnt_d;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_d;
                        end
                    end

`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        // Even parity: the data bits XOR the parity bit must come to zero.
                        if (tick_cnt_q == TICK_LAST) begin
                            tick_cnt_q <= '0;
                            par_bad_q  <= rxs_q ^ (^shift_q);
                            state_q    <= S_STOP;
                        end else begin
                            tick_cnt_q <= tick_cnt_d;
                        end
                    end
`endif

                    S_STOP: begin
                        // Decide at mid stop bit.
                        // Returning to IDLE here leaves half a bit to catch a back-to-back start edge.
                        if (tick_cnt_q == TICK_LAST) begin
                            tick_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                            perr_q     <= par_bad_q;
`endif
                            if (!rxs_q) begin
                                ferr_q  <= 1'b1;
                                state_q <= S_WAIT_HIGH;
                            end
`ifdef UART_RX_PARITY_EN
                            else if (par_bad_q) begin
                                state_q <= S_IDLE;
                            end
`endif
                            else begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                                state_q <= S_IDLE;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_d;
                        end
                    end

                    S_WAIT_HIGH: begin
                        // A break, or a line stuck low, must return high before a new start edge can count.
                        if (rxs_q) begin
                            state_q <= S_IDLE;
                        end
                    end

                    default: begin
                        state_q    <= S_IDLE;
                        tick_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign Rx_data      = data_q;
    assign Rx_valid     = valid_q;
    assign Rx_busy      = (state_q != S_IDLE);
    assign Rx_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign Rx_parity_err = perr_q;
`else
    assign Rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: serial frames are driven against a queue of expected events.
// The expected events are derived from frame contents and framing rules.
// Ticks are strobed every TICK_DIV clks.
// Line edges are placed just after a tick, so frame timing in ticks is deterministic.
module tb_uart_rx_os16;

    localparam int NB       = 8;
    localparam int OS       = 16;
    localparam int TICK_DIV = 4;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    // Ticks counted from the start edge to the Rx_valid (or error) cycle:
    //   1 tick for the first tick to see the low line,
    //   OS/2 ticks to reach mid start bit,
    //   OS ticks per data, parity and stop bit.
    localparam int LAT = 1 + OS / 2 + OS * (NB + PB + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          Rx_tick = 1'b0;
    logic          Rx_in = 1'b1;
    logic [NB-1:0] Rx_data;
    logic          Rx_valid;
    logic          Rx_busy;
    logic          Rx_frame_err;
    logic          Rx_parity_err;

    uart_rx_os16 #(.NUM_BITS(NB), .OS_RATE(OS)) dut (
        .clk          (clk),
        .rst          (rst),
        .Rx_tick      (Rx_tick),
        .Rx_in        (Rx_in),
        .Rx_data      (Rx_data),
        .Rx_valid     (Rx_valid),
        .Rx_busy      (Rx_busy),
        .Rx_frame_err (Rx_frame_err),
        .Rx_parity_err(Rx_parity_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic          fe;
        logic          pe;
        logic [NB-1:0] d;
        int            t0;
    } evt_t;

    evt_t          exp_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            tick_seen = 0;
    logic [NB-1:0] model_data = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Oversample strobe generator.
    initial begin
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            Rx_tick = (c == 0);
            c = (c + 1) % TICK_DIV;
        end
    end

    // Running tick count, used to measure the event latency.
    initial forever begin
        @(posedge clk);
        if (Rx_tick === 1'b1) tick_seen++;
    end

    // Output monitor: every pulse must match the oldest expected event.
    initial begin
        evt_t e;
        logic pv, pf, pp;
        pv = 1'b0;
        pf = 1'b0;
        pp = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
                pf = 1'b0;
                pp = 1'b0;
            end else begin
                if (Rx_valid || Rx_frame_err || Rx_parity_err) begin
                    check_eq("valid_excl", Rx_valid & (Rx_frame_err | Rx_parity_err), 0);
                    check_eq("evt_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check_eq("valid", Rx_valid, e.v);
                        check_eq("frame_err", Rx_frame_err, e.fe);
                        check_eq("parity_err", Rx_parity_err, e.pe);
                        check_eq("latency", tick_seen - e.t0, LAT);
                        if (e.v) begin
                            check_eq("data", Rx_data, e.d);
                            model_data = e.d;
                        end else begin
                            check_eq("data_hold", Rx_data, model_data);
                        end
                    end
                end
                if (Rx_valid)      check_eq("valid_1clk", pv, 0);
                if (Rx_frame_err)  check_eq("ferr_1clk", pf, 0);
                if (Rx_parity_err) check_eq("perr_1clk", pp, 0);
                pv = Rx_valid;
                pf = Rx_frame_err;
                pp = Rx_parity_err;
            end
        end
    end

    task automatic wait_tick();
        do @(posedge clk); while (Rx_tick !== 1'b1);
    endtask

    task automatic align();
        wait_tick();
        @(negedge clk);
    endtask

    // Drive level b for n ticks. The call ends just after a tick, ready for the next edge.
    task automatic hold_line(input logic b, input int n);
        if (n > 0) begin
            Rx_in = b;
            repeat (n) wait_tick();
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [NB-1:0] d, input logic stop, input logic par_flip);
        evt_t e;
        logic perr;
        perr = (PB == 1) && par_flip;
        e.t0 = tick_seen;
        e.d  = d;
        e.fe = !stop;
        e.pe = perr;
        e.v  = stop && !perr;
        exp_q.push_back(e);
        hold_line(1'b0, OS);
        for (int i = 0; i < NB; i++) hold_line(d[i], OS);
        if (PB == 1) hold_line((^d) ^ par_flip, OS);
        hold_line(stop, OS);
    endtask

    task automatic idle_checks(input string tag);
        check_eq({tag, "_pending"}, exp_q.size(), 0);
        check_eq({tag, "_busy"}, Rx_busy, 0);
        check_eq({tag, "_data"}, Rx_data, model_data);
    endtask

    initial begin
        logic [NB-1:0] d;
        logic          stop;
        logic          pf;
        int            gap;

        // Reset values.
        rst = 1'b1;
        Rx_in = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("rst_data", Rx_data, 0);
        check_eq("rst_valid", Rx_valid, 0);
        check_eq("rst_busy", Rx_busy, 0);
        check_eq("rst_ferr", Rx_frame_err, 0);
        check_eq("rst_perr", Rx_parity_err, 0);
        rst = 1'b0;
        align();
        hold_line(1'b1, 2 * OS);

        // Single good frame, then idle.
        send_frame(8'hA5, 1'b1, 1'b0);
        hold_line(1'b1, OS);
        idle_checks("a5");

        // False start: line low for 4 ticks only.
        hold_line(1'b0, 4);
        hold_line(1'b1, 2 * OS);
        idle_checks("false_start");

        // Stop bit low followed by a break, then a good frame once the line is high.
        send_frame(8'h3C, 1'b0, 1'b0);
        hold_line(1'b0, 3 * OS);
        hold_line(1'b1, OS);
        send_frame(8'h81, 1'b1, 1'b0);
        hold_line(1'b1, OS);
        idle_checks("break");

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        hold_line(1'b1, OS);
        idle_checks("b2b");

        // Reset in the middle of the data bits of 0x55 (LSB first: 1,0,1,...).
        hold_line(1'b0, OS);
        hold_line(1'b1, OS);
        hold_line(1'b0, OS);
        hold_line(1'b1, OS / 2);
        check_eq("busy_mid", Rx_busy, 1);
        rst = 1'b1;
        Rx_in = 1'b1;
        model_data = '0;
        repeat (3) @(negedge clk);
        check_eq("midrst_busy", Rx_busy, 0);
        check_eq("midrst_data", Rx_data, 0);
        rst = 1'b0;
        align();
        hold_line(1'b1, 2 * OS);
        idle_checks("midrst");
        send_frame(8'h0F, 1'b1, 1'b0);
        hold_line(1'b1, OS);
        idle_checks("after_rst");

`ifdef UART_RX_PARITY_EN
        // 0x07 has odd weight, so the correct even-parity bit is 1.
        send_frame(8'h07, 1'b1, 1'b1);
        hold_line(1'b1, OS);
        send_frame(8'h07, 1'b1, 1'b0);
        hold_line(1'b1, OS);
        idle_checks("parity");
`endif

        // Randomized frames, gaps and framing errors.
        for (int n = 0; n < 30; n++) begin
            d    = NB'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            pf   = (PB == 1) && ($urandom_range(0, 4) == 0);
            send_frame(d, stop, pf);
            if (!stop) begin
                hold_line(1'b0, $urandom_range(0, 2 * OS));
                hold_line(1'b1, OS + $urandom_range(0, OS));
            end else begin
                gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 3 * OS);
                hold_line(1'b1, gap);
            end
        end
        hold_line(1'b1, 2 * OS);
        idle_checks("random_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Bound on the whole run.
    initial begin
        #900000;
        $display("FAIL watchdog: run exceeded time limit, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
